// File: rtl/fetch_pc_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_if
// Description : Bundle of the fetch sequencer's core-side and instruction-
//               memory-side signals.
//               master : the fetch controller (drives imem_req/imem_addr and
//                        the decode-side instr/instr_valid/pc_out/misalign_err)
//               slave  : the surrounding core and instruction memory
//               Core side   : stall, branch_taken, br_target, instr,
//                             instr_valid, pc_out, misalign_err
//               Memory side : imem_req, imem_addr, imem_ready, imem_rvalid,
//                             imem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        misalign_err;

    modport master (
        input  stall, branch_taken, br_target, imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid, pc_out, misalign_err
    );

    modport slave (
        output stall, branch_taken, br_target, imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid, pc_out, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Program counter and instruction-fetch sequencer. Fetches one
//               instruction per REQ/WAIT handshake, presents it in EXEC and
//               selects the next PC (sequential, branch target, or trap
//               vector on a misaligned taken target).
// Ports       : clk          - rising-edge clock
//               rst_n        - asynchronous active-low reset
//               bus          - fetch_pc_if.master (core + imem signals)
//               retired_cnt  - retired instruction count (FETCH_PERF_CNT_EN)
//               taken_cnt    - taken branch count       (FETCH_PERF_CNT_EN)
// Config      : define FETCH_PERF_CNT_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_pc_if.master        bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       taken_cnt
`endif
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr;
    logic        r_misalign;
    logic        w_misalign_next;
    logic        w_tgt_misaligned;

    assign w_tgt_misaligned = (bus.br_target[1:0] != 2'b00);

    // State register, PC, instruction latch and the registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_instr    <= c_NOP;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
            // Read data is only honoured in WAIT; a stray rvalid in REQ
            // must not disturb the presented instruction.
            if (r_state == S_WAIT && bus.imem_rvalid) begin
                r_instr <= bus.imem_rdata;
            end
        end
    end

    // Next-state and next-PC selection. The PC only moves on EXEC->REQ,
    // so branch inputs seen during a stall have no lasting effect.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_misalign_next = 1'b0;
        case (r_state)
            S_BOOT: w_state_next = S_REQ;
            S_REQ: begin
                if (bus.imem_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!bus.stall) begin
                    w_state_next = S_REQ;
                    if (!bus.branch_taken) begin
                        w_pc_next = r_pc + 32'd4;
                    end else if (w_tgt_misaligned) begin
                        w_pc_next       = TRAP_VEC;
                        w_misalign_next = 1'b1;
                    end else begin
                        w_pc_next = bus.br_target;
                    end
                end
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    // Outputs come straight from registers or state decode.
    assign bus.imem_req     = (r_state == S_REQ);
    assign bus.imem_addr    = r_pc;
    assign bus.pc_out       = r_pc;
    assign bus.instr        = r_instr;
    assign bus.instr_valid  = (r_state == S_EXEC);
    assign bus.misalign_err = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    logic        w_retire;
    logic [31:0] r_retired_cnt;
    logic [31:0] r_taken_cnt;

    assign w_retire = (r_state == S_EXEC) && !bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_cnt <= 32'd0;
            r_taken_cnt   <= 32'd0;
        end else if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
            if (bus.branch_taken) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign taken_cnt   = r_taken_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Self-checking bench for fetch_pc_ctrl. A behavioural memory
//               driver runs one instruction at a time and records what it
//               observed; each test compares those observations with a
//               PC/counter reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_pc_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;
`endif

    fetch_pc_ctrl #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .taken_cnt   (taken_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural PC, pending error pulse, counters.
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_retired;
    logic [31:0] m_taken;

    // Observations from the most recent instruction.
    logic [31:0] o_addr, o_next_addr;
    int          o_period, o_valid_cnt;
    logic        o_addr_stable, o_req_ok, o_instr_ok, o_pc_ok, o_mis_first, o_mis_late;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_pc = RESET_PC; m_mis = 1'b0; m_retired = 32'd0; m_taken = 32'd0;
    endtask

    task automatic model_retire(input logic taken, input logic [31:0] tgt);
        m_retired = m_retired + 32'd1;
        if (taken) m_taken = m_taken + 32'd1;
        if (!taken) begin
            m_pc = m_pc + 32'd4; m_mis = 1'b0;
        end else if (tgt % 4 == 0) begin
            m_pc = tgt; m_mis = 1'b0;
        end else begin
            m_pc = TRAP_VEC; m_mis = 1'b1;
        end
    endtask

    // Runs one instruction starting in the first REQ cycle. Noise on the
    // branch/stall inputs outside EXEC (and during stalls) must be ignored.
    task automatic do_instr(input int rdy_dly, input int rv_dly, input logic [31:0] data,
                            input int stall_n, input logic fin_taken,
                            input logic [31:0] fin_tgt, input logic spurious);
        o_addr = bus.imem_addr; o_mis_first = bus.misalign_err; o_mis_late = 1'b0;
        o_addr_stable = 1'b1; o_req_ok = 1'b1; o_instr_ok = 1'b1; o_pc_ok = 1'b1;
        o_valid_cnt = 0; o_period = 0;
        for (int i = 0; i <= rdy_dly; i++) begin
            if (bus.imem_req !== 1'b1) o_req_ok = 1'b0;
            if (bus.imem_addr !== o_addr) o_addr_stable = 1'b0;
            if (bus.instr_valid) o_valid_cnt++;
            if (i > 0 && bus.misalign_err) o_mis_late = 1'b1;
            bus.imem_ready   = (i == rdy_dly);
            bus.imem_rvalid  = spurious;
            bus.imem_rdata   = ~data;
            bus.stall        = 1'($urandom_range(0, 1));
            bus.branch_taken = 1'($urandom_range(0, 1));
            bus.br_target    = $urandom;
            step; o_period++;
        end
        for (int i = 0; i <= rv_dly; i++) begin
            if (bus.imem_req !== 1'b0) o_req_ok = 1'b0;
            if (bus.instr_valid) o_valid_cnt++;
            if (bus.misalign_err) o_mis_late = 1'b1;
            bus.imem_ready   = 1'($urandom_range(0, 1));
            bus.imem_rvalid  = (i == rv_dly);
            bus.imem_rdata   = (i == rv_dly) ? data : $urandom;
            bus.stall        = 1'($urandom_range(0, 1));
            bus.branch_taken = 1'($urandom_range(0, 1));
            bus.br_target    = $urandom;
            step; o_period++;
        end
        bus.imem_rvalid = 1'b0; bus.imem_ready = 1'b0;
        for (int s = 0; s <= stall_n; s++) begin
            if (bus.imem_req !== 1'b0) o_req_ok = 1'b0;
            if (bus.instr_valid) o_valid_cnt++;
            if (bus.instr !== data) o_instr_ok = 1'b0;
            if (bus.pc_out !== o_addr) o_pc_ok = 1'b0;
            if (bus.misalign_err) o_mis_late = 1'b1;
            bus.stall = (s < stall_n);
            if (s < stall_n) begin
                bus.branch_taken = 1'($urandom_range(0, 1));
                bus.br_target    = $urandom;
            end else begin
                bus.branch_taken = fin_taken;
                bus.br_target    = fin_tgt;
            end
            step; o_period++;
        end
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.imem_ready = 1'b0;
        o_next_addr = bus.imem_addr;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.br_target = 32'd0;
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
        step; step; step;
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
        n_tests++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_addr: got %h expected %h", bus.imem_addr, RESET_PC); end
        n_tests++; if (bus.instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h expected %h", bus.instr, NOP); end
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); end
        n_tests++; if (bus.pc_out !== RESET_PC) begin n_fail++; $display("FAIL rst_pc_out: got %h expected %h", bus.pc_out, RESET_PC); end
        n_tests++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b expected 0", bus.misalign_err); end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (retired_cnt !== 32'd0 || taken_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", retired_cnt, taken_cnt); end
`endif
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0;
        rst_n = 1'b1;
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b expected 0", bus.imem_req); end
        step;
        n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", bus.imem_req); end
        model_reset();
    endtask

    task automatic test_sequential;
        logic [31:0] data;
        for (int k = 0; k < 4; k++) begin
            data = $urandom;
            do_instr(0, 0, data, 0, 1'b0, 32'd0, 1'b0);
            n_tests++; if (o_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr: got %h expected %h", o_addr, 32'(4 * k)); end
            n_tests++; if (o_period !== 3 || o_valid_cnt !== 1) begin n_fail++; $display("FAIL seq_period: got %0d/%0d expected 3/1", o_period, o_valid_cnt); end
            n_tests++; if (!(o_instr_ok && o_pc_ok)) begin n_fail++; $display("FAIL seq_instr_pc: got %b%b expected 11", o_instr_ok, o_pc_ok); end
            model_retire(1'b0, 32'd0);
        end
        n_tests++; if (o_next_addr !== m_pc) begin n_fail++; $display("FAIL seq_next: got %h expected %h", o_next_addr, m_pc); end
    endtask

    task automatic test_branch;
        do_instr(0, 0, $urandom, 0, 1'b1, 32'h40, 1'b0);
        model_retire(1'b1, 32'h40);
        n_tests++; if (o_next_addr !== 32'h40) begin n_fail++; $display("FAIL br_next: got %h expected 00000040", o_next_addr); end
        do_instr(0, 0, $urandom, 0, 1'b0, 32'd0, 1'b0);
        model_retire(1'b0, 32'd0);
        n_tests++; if (o_mis_first !== 1'b0 || o_mis_late !== 1'b0) begin n_fail++; $display("FAIL br_mis: got %b%b expected 00", o_mis_first, o_mis_late); end
    endtask

    task automatic test_misalign;
        do_instr(0, 0, $urandom, 0, 1'b1, 32'h42, 1'b0);
        model_retire(1'b1, 32'h42);
        n_tests++; if (o_next_addr !== TRAP_VEC) begin n_fail++; $display("FAIL mis_next: got %h expected %h", o_next_addr, TRAP_VEC); end
        do_instr(0, 0, $urandom, 0, 1'b0, 32'd0, 1'b0);
        model_retire(1'b0, 32'd0);
        n_tests++; if (o_mis_first !== 1'b1 || o_mis_late !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b%b expected 10", o_mis_first, o_mis_late); end
    endtask

    task automatic test_stall;
        logic [31:0] data;
        data = $urandom;
        do_instr(0, 0, data, 5, 1'b0, 32'h42, 1'b0);
        model_retire(1'b0, 32'h42);
        n_tests++; if (o_valid_cnt !== 6) begin n_fail++; $display("FAIL stall_valid: got %0d expected 6", o_valid_cnt); end
        n_tests++; if (!(o_instr_ok && o_pc_ok)) begin n_fail++; $display("FAIL stall_freeze: got %b%b expected 11", o_instr_ok, o_pc_ok); end
        n_tests++; if (o_next_addr !== m_pc) begin n_fail++; $display("FAIL stall_next: got %h expected %h", o_next_addr, m_pc); end
        do_instr(0, 0, data, 3, 1'b1, 32'h80, 1'b0);
        model_retire(1'b1, 32'h80);
        n_tests++; if (o_next_addr !== 32'h80) begin n_fail++; $display("FAIL stall_br: got %h expected 00000080", o_next_addr); end
    endtask

    task automatic test_handshake;
        do_instr(3, 2, $urandom, 0, 1'b0, 32'd0, 1'b1);
        model_retire(1'b0, 32'd0);
        n_tests++; if (o_period !== 8) begin n_fail++; $display("FAIL hs_period: got %0d expected 8", o_period); end
        n_tests++; if (!(o_addr_stable && o_req_ok)) begin n_fail++; $display("FAIL hs_req: got %b%b expected 11", o_addr_stable, o_req_ok); end
        n_tests++; if (!o_instr_ok) begin n_fail++; $display("FAIL hs_instr: got %b expected 1", o_instr_ok); end
        n_tests++; if (o_next_addr !== m_pc) begin n_fail++; $display("FAIL hs_next: got %h expected %h", o_next_addr, m_pc); end
    endtask

    task automatic test_reset_midop;
        do_instr(0, 0, 32'hDEAD_BEEF, 0, 1'b1, 32'h20, 1'b0);
        model_retire(1'b1, 32'h20);
        n_tests++; if (bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL rm_pc: got %h expected 00000020", bus.imem_addr); end
        bus.imem_ready = 1'b1;
        step;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.imem_addr !== RESET_PC || bus.pc_out !== RESET_PC) begin n_fail++; $display("FAIL rm_addr: got %h/%h expected %h", bus.imem_addr, bus.pc_out, RESET_PC); end
        n_tests++; if (bus.instr !== NOP || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.misalign_err !== 1'b0) begin
            n_fail++; $display("FAIL rm_outs: got instr %h valid %b req %b mis %b expected %h 0 0 0", bus.instr, bus.instr_valid, bus.imem_req, bus.misalign_err, NOP);
        end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (retired_cnt !== 32'd0 || taken_cnt !== 32'd0) begin n_fail++; $display("FAIL rm_cnt_clr: got %0d/%0d expected 0/0", retired_cnt, taken_cnt); end
`endif
        step;
        rst_n = 1'b1;
        step;
        model_reset();
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rm_restart: got req %b addr %h expected 1 %h", bus.imem_req, bus.imem_addr, RESET_PC); end
        do_instr(0, 0, $urandom, 0, 1'b0, 32'd0, 1'b0); model_retire(1'b0, 32'd0);
        do_instr(0, 0, $urandom, 0, 1'b1, 32'h30, 1'b0); model_retire(1'b1, 32'h30);
        do_instr(0, 0, $urandom, 0, 1'b0, 32'd0, 1'b0); model_retire(1'b0, 32'd0);
        n_tests++; if (o_addr !== 32'h30 || o_next_addr !== 32'h34) begin n_fail++; $display("FAIL rm_seq: got %h/%h expected 00000030/00000034", o_addr, o_next_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (retired_cnt !== 32'd3 || taken_cnt !== 32'd1) begin n_fail++; $display("FAIL rm_cnt: got %0d/%0d expected 3/1", retired_cnt, taken_cnt); end
`endif
    endtask

    task automatic test_random;
        int rdy, rv, st;
        logic taken, spur;
        logic [31:0] data, tgt;
        for (int k = 0; k < 24; k++) begin
            rdy = $urandom_range(0, 3); rv = $urandom_range(0, 3); st = $urandom_range(0, 3);
            taken = 1'($urandom_range(0, 1)); spur = 1'($urandom_range(0, 1));
            data = $urandom; tgt = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            do_instr(rdy, rv, data, st, taken, tgt, spur);
            n_tests++; if (o_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr: got %h expected %h", o_addr, m_pc); end
            n_tests++; if (o_period !== rdy + rv + st + 3) begin n_fail++; $display("FAIL rnd_period: got %0d expected %0d", o_period, rdy + rv + st + 3); end
            n_tests++; if (o_valid_cnt !== st + 1) begin n_fail++; $display("FAIL rnd_valid: got %0d expected %0d", o_valid_cnt, st + 1); end
            n_tests++; if (!(o_instr_ok && o_pc_ok && o_req_ok && o_addr_stable)) begin
                n_fail++; $display("FAIL rnd_flags: got %b%b%b%b expected 1111", o_instr_ok, o_pc_ok, o_req_ok, o_addr_stable);
            end
            n_tests++; if (o_mis_first !== m_mis || o_mis_late !== 1'b0) begin n_fail++; $display("FAIL rnd_mis: got %b%b expected %b0", o_mis_first, o_mis_late, m_mis); end
            model_retire(taken, tgt);
            n_tests++; if (o_next_addr !== m_pc) begin n_fail++; $display("FAIL rnd_next: got %h expected %h", o_next_addr, m_pc); end
`ifdef FETCH_PERF_CNT_EN
            n_tests++; if (retired_cnt !== m_retired || taken_cnt !== m_taken) begin
                n_fail++; $display("FAIL rnd_cnt: got %0d/%0d expected %0d/%0d", retired_cnt, taken_cnt, m_retired, m_taken);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_misalign();
        test_stall();
        test_handshake();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
